// File: rtl/simd_mac_pkg.sv
// Shared types, default widths and saturating arithmetic for the SIMD MAC array.
// Helpers work on a 64-bit signed container so any configured width up to 63 bits fits.
package simd_mac_pkg;

  localparam int LANES_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int OUT_W_DEF   = 8;
  localparam int LEN_W_DEF   = 8;
  localparam int SHIFT_W_DEF = 4;
  localparam int CALC_W      = 64;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACT, S_OUT} state_e;

  typedef logic signed [CALC_W-1:0] wide_t;

  // Clamp v to the signed range of a w-bit value.
  function automatic wide_t clamp(input wide_t v, input int w);
    wide_t hi, lo, r;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                    output logic ovf);
    wide_t s, r;
    s   = a + b;
    r   = clamp(s, w);
    ovf = (r != s);
    return r;
  endfunction

endpackage

// File: rtl/simd_mac_lane.sv
// One MAC lane: signed multiply, saturating accumulate with sticky flag,
// and ReLU / arithmetic-shift / clamp requantisation into registered outputs.
module simd_mac_lane
  import simd_mac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic signed [ACC_W-1:0]   init_i,
  input  logic                      beat_i,
  input  logic signed [DATA_W-1:0]  data_i,
  input  logic signed [DATA_W-1:0]  weight_i,
  input  logic                      act_i,
  input  logic                      relu_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  output logic signed [ACC_W-1:0]   out_acc_o,
  output logic signed [OUT_W-1:0]   out_act_o,
  output logic                      sat_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, out_acc_q;
  logic signed [OUT_W-1:0]    act_d, out_act_q;
  logic                       sat_q, ovf;
  wide_t                      sum_w, act_w;

  always_comb begin
    prod  = data_i * weight_i;
    sum_w = sat_add(wide_t'(acc_q), wide_t'(prod), ACC_W, ovf);
    acc_d = ACC_W'(sum_w);
    act_w = wide_t'(acc_q);
    if (relu_i && (acc_q < 0)) act_w = '0;
    act_w = act_w >>> shift_i;
    act_d = OUT_W'(clamp(act_w, OUT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_act_q <= '0;
    end else begin
      if (clr_i) begin
        acc_q <= init_i;
        sat_q <= 1'b0;
      end else if (beat_i) begin
        acc_q <= acc_d;
        if (ovf) sat_q <= 1'b1;
      end
      if (act_i) begin
        out_acc_q <= acc_q;
        out_act_q <= act_d;
      end
    end
  end

  assign out_acc_o = out_acc_q;
  assign out_act_o = out_act_q;
  assign sat_o     = sat_q;

endmodule

// File: rtl/simd_mac_array_v2.sv
// Multi-lane SIMD dot-product MAC with valid/ready handshakes and requantised outputs.
// Optional SIMD_MAC_BIAS_EN adds in_bias, loaded into the accumulators on an accepted start.
module simd_mac_array_v2
  import simd_mac_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_relu,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*DATA_W-1:0]   in_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_acc,
  output logic [LANES*OUT_W-1:0]    out_act,
  output logic [LANES-1:0]          sat_flags,
  output logic                      busy
`ifdef SIMD_MAC_BIAS_EN
  ,
  input  logic [LANES*ACC_W-1:0]    in_bias
`endif
);

  state_e               state_q;
  logic [LEN_W-1:0]     len_q, cnt_q;
  logic                 relu_q, out_valid_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 start_acc, beat, act_en;

  assign start_acc = (state_q == S_IDLE) && start && (cfg_len != '0);
  assign beat      = (state_q == S_ACCUM) && in_valid;
  assign act_en    = (state_q == S_ACT);
  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_acc) begin
          len_q   <= cfg_len;
          relu_q  <= cfg_relu;
          shift_q <= cfg_shift;
          cnt_q   <= '0;
          state_q <= S_ACCUM;
        end
        S_ACCUM: if (beat) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_q   <= '0;
            state_q <= S_ACT;
          end else begin
            cnt_q   <= cnt_q + LEN_W'(1);
          end
        end
        S_ACT: begin
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ACC_W-1:0] init;
`ifdef SIMD_MAC_BIAS_EN
    assign init = in_bias[i*ACC_W +: ACC_W];
`else
    assign init = '0;
`endif
    simd_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (start_acc),
      .init_i   (init),
      .beat_i   (beat),
      .data_i   (in_data[i*DATA_W +: DATA_W]),
      .weight_i (in_weight[i*DATA_W +: DATA_W]),
      .act_i    (act_en),
      .relu_i   (relu_q),
      .shift_i  (shift_q),
      .out_acc_o(out_acc[i*ACC_W +: ACC_W]),
      .out_act_o(out_act[i*OUT_W +: OUT_W]),
      .sat_o    (sat_flags[i])
    );
  end

endmodule

// File: tb/tb_simd_mac_array_v2.sv
// Bench for simd_mac_array_v2: directed vector table plus random jobs against a
// plain-arithmetic reference model, with reset/abort and zero-length start sequences.
module tb_simd_mac_array_v2;

  localparam int L = 4;

  logic         clk = 0;
  logic         rst, start, cfg_relu, in_valid, out_ready;
  logic [7:0]   cfg_len;
  logic [3:0]   cfg_shift;
  logic [31:0]  in_data, in_weight;
  logic         in_ready, out_valid, busy;
  logic [63:0]  out_acc;
  logic [31:0]  out_act;
  logic [3:0]   sat_flags;

  always #5 clk = ~clk;

  simd_mac_array_v2 dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_act(out_act),
    .sat_flags(sat_flags), .busy(busy)
`ifdef SIMD_MAC_BIAS_EN
    , .in_bias('0)
`endif
  );

  typedef struct packed {
    logic [7:0]            len;
    logic                  relu;
    logic [3:0]            shift;
    logic                  bub;
    logic [3:0]            hold;
    logic [3:0][3:0][7:0]  d;     // [beat][lane]
    logic [3:0][3:0][7:0]  w;
    logic [3:0][15:0]      eacc;
    logic [3:0][7:0]       eact;
    logic [3:0]            esat;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];
  int   cur_d [L][16];
  int   cur_w [L][16];
  int   nchk = 0, nerr = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: per-beat saturating sum, then relu, shift, clamp.
  function automatic void model(input int len, input int relu, input int shift, input int l,
                                output longint acc, output longint act, output bit sat);
    longint v;
    acc = 0; sat = 0;
    for (int k = 0; k < len; k++) begin
      acc += longint'(cur_d[l][k] * cur_w[l][k]);
      if (acc > 32767)  begin acc = 32767;  sat = 1; end
      if (acc < -32768) begin acc = -32768; sat = 1; end
    end
    v = acc;
    if (relu != 0 && v < 0) v = 0;
    v = v >>> shift;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    act = v;
  endfunction

  task automatic setv(input int v, input int len, input int relu, input int sh,
                      input int bub, input int hold, input int esat);
    tbl[v] = '0;
    tbl[v].len = 8'(len); tbl[v].relu = relu[0]; tbl[v].shift = 4'(sh);
    tbl[v].bub = bub[0];  tbl[v].hold = 4'(hold); tbl[v].esat = 4'(esat);
  endtask

  task automatic bt(input int v, input int k, input int l, input int dd, input int ww);
    tbl[v].d[k][l] = 8'(dd);
    tbl[v].w[k][l] = 8'(ww);
  endtask

  task automatic ex(input int v, input int l, input int acc, input int act);
    tbl[v].eacc[l] = 16'(acc);
    tbl[v].eact[l] = 8'(act);
  endtask

  task automatic run_job(input int len, input int relu, input int shift,
                         input bit bub, input int hold);
    logic [63:0] eacc;
    logic [31:0] eact;
    logic [3:0]  esat;
    longint a, t;
    bit s, acc_now;
    int k, cyc;
    for (int l = 0; l < L; l++) begin
      model(len, relu, shift, l, a, t, s);
      eacc[l*16 +: 16] = 16'(a);
      eact[l*8 +: 8]   = 8'(t);
      esat[l]          = s;
    end
    cfg_len = 8'(len); cfg_relu = relu[0]; cfg_shift = 4'(shift); start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("sat_cleared_on_start", sat_flags, 0);
    k = 0; cyc = 0;
    while (k < len && cyc < 200) begin
      in_valid = bub ? (cyc % 2 == 0) : 1'b1;
      for (int l = 0; l < L; l++) begin
        in_data[l*8 +: 8]   = 8'(cur_d[l][k]);
        in_weight[l*8 +: 8] = 8'(cur_w[l][k]);
      end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) k++;
      cyc++;
    end
    in_valid = 0;
    if (k < len) chk("beat_timeout", k, len);
    chk("act_cycle_out_valid_low", out_valid, 0);
    chk("act_cycle_in_ready_low", in_ready, 0);
    out_ready = (hold == 0);
    @(posedge clk); #1;
    chk("out_valid_rise", out_valid, 1);
    chk("out_acc", out_acc, eacc);
    chk("out_act", out_act, eact);
    chk("sat_flags", sat_flags, esat);
    for (int h = 0; h < hold; h++) begin
      start = 1; cfg_len = 8'd3;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_acc", out_acc, eacc);
      chk("hold_out_act", out_act, eact);
    end
    start = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release_out_valid", out_valid, 0);
    chk("release_busy", busy, 0);
    chk("idle_out_acc_held", out_acc, eacc);
    chk("idle_out_act_held", out_act, eact);
    chk("idle_sat_held", sat_flags, esat);
  endtask

  task automatic run_tbl(input int v);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < L; l++) begin
        cur_d[l][k] = int'($signed(tbl[v].d[k][l]));
        cur_w[l][k] = int'($signed(tbl[v].w[k][l]));
      end
    run_job(int'(tbl[v].len), int'(tbl[v].relu), int'(tbl[v].shift), tbl[v].bub,
            int'(tbl[v].hold));
    for (int l = 0; l < L; l++) begin
      chk($sformatf("tbl%0d_acc%0d", v, l), $signed(out_acc[l*16 +: 16]), $signed(tbl[v].eacc[l]));
      chk($sformatf("tbl%0d_act%0d", v, l), $signed(out_act[l*8 +: 8]), $signed(tbl[v].eact[l]));
    end
    chk($sformatf("tbl%0d_sat", v), sat_flags, tbl[v].esat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1; start = 0; cfg_len = 0; cfg_relu = 0; cfg_shift = 0;
    in_valid = 0; in_data = 0; in_weight = 0; out_ready = 0;

    // basic dot product
    setv(0, 3, 0, 0, 0, 0, 0);
    bt(0,0,0,2,5); bt(0,1,0,3,6); bt(0,2,0,4,7);
    for (int k = 0; k < 3; k++) bt(0,k,1,-3,4);
    bt(0,0,2,50,40);
    bt(0,0,3,-100,100); bt(0,1,3,-100,100);
    ex(0,0,56,56); ex(0,1,-36,-36); ex(0,2,2000,127); ex(0,3,-20000,-128);
    // relu + shift, with output backpressure
    tbl[1] = tbl[0];
    tbl[1].relu = 1; tbl[1].shift = 4'd2; tbl[1].hold = 4'd5;
    ex(1,0,56,14); ex(1,1,-36,0); ex(1,2,2000,127); ex(1,3,-20000,0);
    // positive saturation on lane 0
    setv(2, 2, 0, 0, 0, 0, 4'b0001);
    for (int k = 0; k < 2; k++) begin
      bt(2,k,0,-128,-128); bt(2,k,1,127,127); bt(2,k,2,-128,127);
    end
    ex(2,0,32767,127); ex(2,1,32258,127); ex(2,2,-32512,-128); ex(2,3,0,0);
    // bubbles on in_valid
    setv(3, 4, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      bt(3,k,0,k+1,k+1); bt(3,k,1,-(k+1),k+1); bt(3,k,2,10,10); bt(3,k,3,-10,10);
    end
    ex(3,0,30,30); ex(3,1,-30,-30); ex(3,2,400,127); ex(3,3,-400,-128);
    // maximum shift
    setv(4, 1, 0, 15, 0, 1, 0);
    bt(4,0,0,-128,-128); bt(4,0,1,-128,127); bt(4,0,2,127,127); bt(4,0,3,1,1);
    ex(4,0,16384,0); ex(4,1,-16256,-1); ex(4,2,16129,0); ex(4,3,1,0);
    // negative saturation with relu
    setv(5, 3, 1, 4, 0, 0, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      bt(5,k,0,-128,127); bt(5,k,1,127,-128); bt(5,k,2,100,100); bt(5,k,3,-5,7);
    end
    ex(5,0,-32768,0); ex(5,1,-32768,0); ex(5,2,30000,127); ex(5,3,-105,0);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_act", out_act, 0);
    chk("rst_sat", sat_flags, 0);

    for (int v = 0; v < NV; v++) run_tbl(v);

    for (int j = 0; j < 20; j++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int l = 0; l < L; l++)
        for (int k = 0; k < len; k++) begin
          cur_d[l][k] = int'($urandom_range(0, 255)) - 128;
          cur_w[l][k] = int'($urandom_range(0, 255)) - 128;
        end
      run_job(len, int'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // abort mid-ACCUM after two beats
    cfg_len = 8'd4; cfg_relu = 0; cfg_shift = 0; start = 1;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_data = 32'h05050505; in_weight = 32'h07070707;
    repeat (2) @(posedge clk);
    #1 in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_acc", out_acc, 0);
    chk("abort_out_act", out_act, 0);
    chk("abort_sat", sat_flags, 0);
    seen = 0;
    in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    in_valid = 0;
    chk("abort_no_activity", seen, 0);

    // zero-length start is ignored
    cfg_len = 8'd0; start = 1;
    @(posedge clk); #1;
    chk("len0_busy", busy, 0);
    chk("len0_in_ready", in_ready, 0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    start = 0;
    chk("len0_no_activity", seen, 0);

    run_tbl(0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
